// File: rtl/mpc_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mpc_rx_ctrl
// Purpose  : MPC-response DDR demux sequencer with delayed strobe capture.
//            Optional statistics counters are enabled by `define MPC_RX_STATS_EN.
// Revision : 1.0
// ============================================================================
module mpc_rx_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DLY_BITS = 4,
  parameter int CNT_BITS = 12
) (
  input  logic                clock,
  input  logic                global_reset,
  input  logic                mpc_rx_en,
  input  logic                ttc_resync,
  input  logic                mpc_tx_strobe,
  input  logic [DLY_BITS-1:0] mpc_delay,
  input  logic [WIDTH-1:0]    dout1st,
  input  logic [WIDTH-1:0]    dout2nd,
  output logic                demux_set,
  output logic                rx_ready,
  output logic                rx_valid,
  output logic                rx_miss,
  output logic [WIDTH-1:0]    rx_data1st,
  output logic [WIDTH-1:0]    rx_data2nd,
  output logic [CNT_BITS-1:0] rx_nvalid,
  output logic [CNT_BITS-1:0] rx_nmiss
);

  localparam int SR_LEN = 2**DLY_BITS;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            flush_cnt_q, flush_cnt_d;
  logic                  demux_set_q;
  logic [SR_LEN-2:0]     sr_q, sr_d;
  logic [DLY_BITS-1:0]   delay_q;
  logic [SR_LEN-1:0]     taps;
  logic                  run, delay_chg, hit, both_ones;
  logic                  rx_valid_q, rx_miss_q;
  logic [WIDTH-1:0]      rx_data1st_q, rx_data2nd_q;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (mpc_rx_en && !ttc_resync) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 2'd0;
        end
      end
      ST_FLUSH: begin
        if (!mpc_rx_en || ttc_resync) begin
          state_d = ST_HOLD;
        end else if (flush_cnt_q == 2'd2) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      ST_RUN: begin
        if (!mpc_rx_en || ttc_resync) begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // Tap 0 is the live strobe so that a zero delay captures on the strobe's own edge.
  always_comb begin
    run       = (state_q == ST_RUN);
    delay_chg = (mpc_delay != delay_q);
    taps      = {sr_q, mpc_tx_strobe & run};
    hit       = taps[mpc_delay] & run & ~ttc_resync & ~delay_chg;
    both_ones = (&dout1st) & (&dout2nd);
    sr_d      = (!run || delay_chg) ? '0 : taps[SR_LEN-2:0];
  end

  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state_q      <= ST_HOLD;
      flush_cnt_q  <= 2'd0;
      demux_set_q  <= 1'b1;
      sr_q         <= '0;
      delay_q      <= '0;
      rx_valid_q   <= 1'b0;
      rx_miss_q    <= 1'b0;
      rx_data1st_q <= '1;
      rx_data2nd_q <= '1;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      demux_set_q <= (state_d == ST_HOLD);
      sr_q        <= sr_d;
      delay_q     <= mpc_delay;
      rx_valid_q  <= hit;
      rx_miss_q   <= hit & both_ones;
      if (hit) begin
        rx_data1st_q <= dout1st;
        rx_data2nd_q <= dout2nd;
      end
    end
  end

  assign demux_set  = demux_set_q;
  assign rx_ready   = run;
  assign rx_valid   = rx_valid_q;
  assign rx_miss    = rx_miss_q;
  assign rx_data1st = rx_data1st_q;
  assign rx_data2nd = rx_data2nd_q;

`ifdef MPC_RX_STATS_EN
  logic [CNT_BITS-1:0] nvalid_q, nmiss_q;

  // Counters saturate rather than wrap so a stuck link stays visible.
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      nvalid_q <= '0;
      nmiss_q  <= '0;
    end else if (ttc_resync) begin
      nvalid_q <= '0;
      nmiss_q  <= '0;
    end else begin
      if (hit && (nvalid_q != '1)) begin
        nvalid_q <= nvalid_q + 1'b1;
      end
      if (hit && both_ones && (nmiss_q != '1)) begin
        nmiss_q <= nmiss_q + 1'b1;
      end
    end
  end

  assign rx_nvalid = nvalid_q;
  assign rx_nmiss  = nmiss_q;
`else
  assign rx_nvalid = '0;
  assign rx_nmiss  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mpc_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpc_rx_ctrl
// Purpose  : Directed scoreboard bench for mpc_rx_ctrl (MPC_RX_STATS_EN aware).
// Revision : 1.0
// ============================================================================
module tb_mpc_rx_ctrl;

  localparam int WIDTH    = 8;
  localparam int DLY_BITS = 4;
  localparam int CNT_BITS = 4;
`ifdef MPC_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic             miss;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                resync;
  logic                strobe;
  logic [DLY_BITS-1:0] delay;
  logic [WIDTH-1:0]    dout1;
  logic [WIDTH-1:0]    dout2;
  logic                demux_set;
  logic                rx_ready;
  logic                rx_valid;
  logic                rx_miss;
  logic [WIDTH-1:0]    rx_data1st;
  logic [WIDTH-1:0]    rx_data2nd;
  logic [CNT_BITS-1:0] rx_nvalid;
  logic [CNT_BITS-1:0] rx_nmiss;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks      = 0;
  int   failures    = 0;
  int   nvalid_seen = 0;
  int   npushed     = 0;

  mpc_rx_ctrl #(
    .WIDTH    (WIDTH),
    .DLY_BITS (DLY_BITS),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .clock         (clk),
    .global_reset  (rst),
    .mpc_rx_en     (en),
    .ttc_resync    (resync),
    .mpc_tx_strobe (strobe),
    .mpc_delay     (delay),
    .dout1st       (dout1),
    .dout2nd       (dout2),
    .demux_set     (demux_set),
    .rx_ready      (rx_ready),
    .rx_valid      (rx_valid),
    .rx_miss       (rx_miss),
    .rx_data1st    (rx_data1st),
    .rx_data2nd    (rx_data2nd),
    .rx_nvalid     (rx_nvalid),
    .rx_nmiss      (rx_nmiss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2, input logic m);
    exp_t e;
    e.d1   = d1;
    e.d2   = d2;
    e.miss = m;
    exp_q.push_back(e);
    npushed++;
  endtask

  // One bx: drive inputs, let the next rising edge sample them, return at the falling edge.
  task automatic cyc(input logic s, input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2);
    strobe = s;
    dout1  = d1;
    dout2  = d2;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      nvalid_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(rx_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("data1st", 32'(rx_data1st), 32'(mon_e.d1));
        chk("data2nd", 32'(rx_data2nd), 32'(mon_e.d2));
        chk("miss",    32'(rx_miss),    32'(mon_e.miss));
      end
    end
  end

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    resync = 1'b0;
    strobe = 1'b0;
    delay  = '0;
    dout1  = '0;
    dout2  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_demux_set", 32'(demux_set),  32'd1);
    chk("rst_rx_ready",  32'(rx_ready),   32'd0);
    chk("rst_rx_valid",  32'(rx_valid),   32'd0);
    chk("rst_data1st",   32'(rx_data1st), 32'hFF);
    chk("rst_data2nd",   32'(rx_data2nd), 32'hFF);
    chk("rst_nvalid",    32'(rx_nvalid),  32'd0);

    // Release and flush
    rst = 1'b0;
    en  = 1'b1;
    cyc(1'b0, 8'h00, 8'h00);
    chk("flush_demux_set", 32'(demux_set), 32'd0);
    chk("flush_ready0",    32'(rx_ready),  32'd0);
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    chk("flush_ready_last", 32'(rx_ready), 32'd0);
    cyc(1'b0, 8'h00, 8'h00);
    chk("run_ready", 32'(rx_ready), 32'd1);

    // D=0 single capture, then hold
    push(8'hA5, 8'h3C, 1'b0);
    cyc(1'b1, 8'hA5, 8'h3C);
    cyc(1'b0, 8'h00, 8'h00);
    chk("d0_valid_drop", 32'(rx_valid),   32'd0);
    chk("d0_hold_data",  32'(rx_data1st), 32'hA5);

    // D=5 back-to-back strobes
    delay = 4'd5;
    cyc(1'b0, 8'h00, 8'h00);
    push(8'h11, 8'h22, 1'b0);
    cyc(1'b1, 8'h00, 8'h00);
    push(8'h33, 8'h44, 1'b0);
    cyc(1'b1, 8'h00, 8'h00);
    push(8'h55, 8'h66, 1'b0);
    cyc(1'b1, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    chk("d5_not_early", 32'(rx_valid), 32'd0);
    cyc(1'b0, 8'h11, 8'h22);
    cyc(1'b0, 8'h33, 8'h44);
    cyc(1'b0, 8'h55, 8'h66);
    cyc(1'b0, 8'h00, 8'h00);

    // Missing-response detection
    delay = 4'd0;
    cyc(1'b0, 8'h00, 8'h00);
    push(8'hFF, 8'hFF, 1'b1);
    cyc(1'b1, 8'hFF, 8'hFF);
    push(8'hFF, 8'h00, 1'b0);
    cyc(1'b1, 8'hFF, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    chk("nvalid_pre_resync", 32'(rx_nvalid), STATS ? 32'd6 : 32'd0);
    chk("nmiss_pre_resync",  32'(rx_nmiss),  STATS ? 32'd1 : 32'd0);

    // Resync drops an in-flight capture and re-flushes
    delay = 4'd7;
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b1, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    resync = 1'b1;
    cyc(1'b0, 8'h00, 8'h00);
    resync = 1'b0;
    chk("resync_demux_set", 32'(demux_set), 32'd1);
    chk("resync_ready",     32'(rx_ready),  32'd0);
    chk("resync_nvalid",    32'(rx_nvalid), 32'd0);
    cyc(1'b0, 8'hFF, 8'hFF);
    chk("reflush_demux_set", 32'(demux_set), 32'd0);
    cyc(1'b1, 8'hFF, 8'hFF);
    cyc(1'b0, 8'hFF, 8'hFF);
    chk("reflush_ready0", 32'(rx_ready), 32'd0);
    cyc(1'b0, 8'hFF, 8'hFF);
    chk("reflush_ready1", 32'(rx_ready), 32'd1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'hFF, 8'hFF);

    // Delay change while a strobe is in flight
    delay = 4'd3;
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b1, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    delay = 4'd4;
    cyc(1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h99, 8'h99);
    chk("dchg_nvalid", 32'(rx_nvalid), 32'd0);
    push(8'h77, 8'h88, 1'b0);
    cyc(1'b1, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b0, 8'h00, 8'h00);
    cyc(1'b0, 8'h77, 8'h88);
    cyc(1'b0, 8'h00, 8'h00);

    // Twenty captures drive the counters into saturation
    delay = 4'd0;
    cyc(1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) begin
      logic [WIDTH-1:0] d;
      d = WIDTH'(i * 7 + 1);
      push(d, ~d, 1'b0);
      cyc(1'b1, d, ~d);
    end
    cyc(1'b0, 8'h00, 8'h00);
    chk("nvalid_saturated", 32'(rx_nvalid), STATS ? 32'd15 : 32'd0);
    chk("nmiss_final",      32'(rx_nmiss),  32'd0);

    // Disable returns to HOLD
    en = 1'b0;
    cyc(1'b0, 8'h00, 8'h00);
    chk("dis_demux_set", 32'(demux_set), 32'd1);
    chk("dis_ready",     32'(rx_ready),  32'd0);

    cyc(1'b0, 8'h00, 8'h00);
    chk("queue_empty",  32'(exp_q.size()), 32'd0);
    chk("valid_count",  32'(nvalid_seen),  32'(npushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
